lab6_seq_checker: RTL and testbench



---
 rtl/lab6_seq_checker.sv | 155 +++++++++++++++
 tb/tb_lab6_seq_checker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/lab6_seq_checker.sv
// Receive-side lock checker for the lab 6 {z,y,x} light-sequence generator.
// Optional SEQCHK_ILLEGAL_EN adds an 'illegal' pulse output for never-valid patterns.
module lab6_seq_checker #(
  parameter int unsigned LOCK_CYCLES = 8,
  parameter int unsigned MISS_LIMIT  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             locked,
  output logic             err,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] err_cnt
`ifdef SEQCHK_ILLEGAL_EN
  ,
  output logic             illegal
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_V = LOCK_CYCLES[7:0];
  localparam logic [3:0] MISS_V = MISS_LIMIT[3:0];

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [7:0]       match_cnt_q, match_cnt_d, match_inc;
  logic [3:0]       miss_cnt_q, miss_cnt_d, miss_inc;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       s;
  logic             hit;

  function automatic logic [2:0] exp_sample(input logic [2:0] idx);
    case (idx)
      3'd0:                  exp_sample = 3'b110;
      3'd1:                  exp_sample = 3'b111;
      3'd2, 3'd3, 3'd4:      exp_sample = 3'b001;
      default:               exp_sample = 3'b100;
    endcase
  endfunction

  always_comb begin
    s           = {z, y, x};
    hit         = (s == exp_sample(phase_q));
    match_inc   = match_cnt_q + 8'd1;
    miss_inc    = miss_cnt_q + 4'd1;
    state_d     = state_q;
    phase_d     = phase_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      HUNT: begin
        locked_d = 1'b0;
        if (s == 3'b110) begin
          state_d     = SYNC;
          match_cnt_d = 8'd1;
          phase_d     = 3'd1;
        end else begin
          phase_d = 3'd0;
        end
      end
      SYNC: begin
        if (hit) begin
          phase_d     = phase_q + 3'd1;
          match_cnt_d = match_inc;
          if (match_inc == LOCK_V) begin
            state_d    = LOCKED;
            locked_d   = 1'b1;
            miss_cnt_d = '0;
          end
        end else if (s == 3'b110) begin
          match_cnt_d = 8'd1;
          phase_d     = 3'd1;
        end else begin
          state_d     = HUNT;
          phase_d     = 3'd0;
          match_cnt_d = '0;
        end
      end
      LOCKED: begin
        // Flywheel: phase keeps advancing through isolated misses.
        phase_d = phase_q + 3'd1;
        if (hit) begin
          miss_cnt_d = '0;
        end else begin
          err_d      = 1'b1;
          miss_cnt_d = miss_inc;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (miss_inc == MISS_V) begin
            state_d     = HUNT;
            locked_d    = 1'b0;
            phase_d     = 3'd0;
            miss_cnt_d  = '0;
            match_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d     = HUNT;
        phase_d     = 3'd0;
        match_cnt_d = '0;
        miss_cnt_d  = '0;
        locked_d    = 1'b0;
      end
    endcase
  end

`ifdef SEQCHK_ILLEGAL_EN
  logic illegal_q, illegal_d;
  always_comb illegal_d = (s inside {3'b000, 3'b010, 3'b011, 3'b101});
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      phase_q     <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign phase   = phase_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lab6_seq_checker.sv
// Directed bench for lab6_seq_checker: a default instance plus a CNT_W=2 instance
// fed identical stimulus to exercise counter saturation.
module tb_lab6_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0, y = 1'b0, z = 1'b1;
  logic       locked, err, locked2, err2;
  logic [2:0] phase, phase2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
`ifdef SEQCHK_ILLEGAL_EN
  logic       illegal, illegal2;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [2:0] seq [8] = '{3'b110, 3'b111, 3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b100};

  always #5 clk = ~clk;

  lab6_seq_checker #(.LOCK_CYCLES(8), .MISS_LIMIT(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
    .locked(locked), .err(err), .phase(phase), .err_cnt(err_cnt)
`ifdef SEQCHK_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  lab6_seq_checker #(.LOCK_CYCLES(8), .MISS_LIMIT(2), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
    .locked(locked2), .err(err2), .phase(phase2), .err_cnt(err_cnt2)
`ifdef SEQCHK_ILLEGAL_EN
    , .illegal(illegal2)
`endif
  );

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one sample, let it be captured, then observe 1 time unit after the edge.
  task automatic send(input logic [2:0] s);
    {z, y, x} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_chk(input string tag, input logic [2:0] s, input int unsigned ph,
                          input int unsigned lk, input int unsigned er);
    send(s);
    check({tag, ".phase"}, phase, ph);
    check({tag, ".locked"}, locked, lk);
    check({tag, ".err"}, err, er);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send(3'b100);
    send(3'b100);
    rst = 1'b0;
  endtask

  // Startup 100 then one clean period; locked rises on the 8th sample from 110.
  task automatic lock_up(input string tag);
    send_chk({tag, ".startup"}, 3'b100, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      send_chk({tag, ".acq"}, seq[i], (i + 1) % 8, (i == 7) ? 1 : 0, 0);
  endtask

  initial begin
    // 1: reset and free-running generator
    do_reset();
    check("rst.locked", locked, 0);
    check("rst.err", err, 0);
    check("rst.phase", phase, 0);
    check("rst.err_cnt", err_cnt, 0);
    lock_up("t1");
    for (int p = 0; p < 25; p++)
      for (int i = 0; i < 8; i++)
        send_chk("t1.run", seq[i], (i + 1) % 8, 1, 0);
    check("t1.err_cnt", err_cnt, 0);

    // 2: single corruption at index 3 while locked
    for (int i = 0; i < 3; i++) send_chk("t2.pre", seq[i], i + 1, 1, 0);
    send_chk("t2.bad", 3'b100, 4, 1, 1);
    check("t2.err_cnt", err_cnt, 1);
    for (int i = 4; i < 8; i++) send_chk("t2.post", seq[i], (i + 1) % 8, 1, 0);
    check("t2.err_cnt_hold", err_cnt, 1);

    // 3: two consecutive misses drop lock, then relock
    do_reset();
    lock_up("t3");
    for (int i = 0; i < 5; i++) send_chk("t3.pre", seq[i], i + 1, 1, 0);
    send_chk("t3.miss1", 3'b000, 6, 1, 1);
    check("t3.cnt1", err_cnt, 1);
    send_chk("t3.miss2", 3'b000, 0, 0, 1);
    check("t3.cnt2", err_cnt, 2);
    send_chk("t3.hunt", seq[7], 0, 0, 0);
    for (int i = 0; i < 8; i++)
      send_chk("t3.relock", seq[i], (i + 1) % 8, (i == 7) ? 1 : 0, 0);

    // 4: mismatch during SYNC returns to HUNT; 110 mismatch re-syncs
    do_reset();
    send_chk("t4.startup", 3'b100, 0, 0, 0);
    for (int i = 0; i < 3; i++) send_chk("t4.sync", seq[i], i + 1, 0, 0);
    send_chk("t4.bad", 3'b111, 0, 0, 0);
    for (int i = 4; i < 8; i++) send_chk("t4.hunt", seq[i], 0, 0, 0);
    send_chk("t4.s0", 3'b110, 1, 0, 0);
    send_chk("t4.s1", 3'b111, 2, 0, 0);
    send_chk("t4.resync", 3'b110, 1, 0, 0);
    for (int i = 1; i < 8; i++)
      send_chk("t4.lock", seq[i], (i + 1) % 8, (i == 7) ? 1 : 0, 0);
    check("t4.err_cnt", err_cnt, 0);

    // 5: isolated corruptions; CNT_W=2 instance saturates at 3
    do_reset();
    lock_up("t5");
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 3; i++) send(seq[i]);
      send_chk("t5.bad", 3'b100, 4, 1, 1);
      check("t5.cnt8", err_cnt, k);
      check("t5.cnt2", err_cnt2, (k < 3) ? k : 3);
      check("t5.locked2", locked2, 1);
      for (int i = 4; i < 8; i++) send_chk("t5.post", seq[i], (i + 1) % 8, 1, 0);
    end

    // 6: reset while locked with err_cnt=5, pending mismatch suppressed
    for (int i = 0; i < 3; i++) send_chk("t6.pre", seq[i], i + 1, 1, 0);
    rst = 1'b1;
    send_chk("t6.rst", 3'b000, 0, 0, 0);
    check("t6.err_cnt", err_cnt, 0);
    check("t6.err_cnt2", err_cnt2, 0);
`ifdef SEQCHK_ILLEGAL_EN
    check("t6.rst_illegal", illegal, 0);
`endif
    rst = 1'b0;
    send_chk("t6.ill", 3'b010, 0, 0, 0);
`ifdef SEQCHK_ILLEGAL_EN
    check("t6.illegal_pulse", illegal, 1);
`endif
    send_chk("t6.after", 3'b100, 0, 0, 0);
`ifdef SEQCHK_ILLEGAL_EN
    check("t6.illegal_clear", illegal, 0);
`endif
    send_chk("t6.hunt", 3'b110, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
